// File: rtl/prog_clkdiv.sv
// prog_clkdiv: programmable clock divider with tick pulse, square wave and
// an up/down tick counter.
//
// Ports:
//   CLOCK_50 - single clock, all state changes on its rising edge
//   reset_n  - synchronous active-low reset
//   en       - prescaler and counter advance only while high
//   div      - divisor; tick period is div+1 enabled cycles
//   load     - synchronous restart of prescaler, counter and square wave
//   dir      - counter direction (1 = up, 0 = down), sampled on wrap edges
//   tick     - registered one-cycle pulse, once per period
//   sq       - registered square wave, toggles on every tick
//   count    - registered tick counter, modulo 2^CNT_W
//   tc       - terminal count for the current direction (combinational)
module prog_clkdiv #(
  parameter int unsigned DIV_W = 26,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic             dir,
  output logic             tick,
  output logic             sq,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  // Divisor is only re-sampled on a wrap edge or load, so a period already
  // in progress always completes with the divisor it started with.
  always_comb begin
    pre_d   = pre_q;
    div_d   = div_q;
    count_d = count_q;
    sq_d    = sq_q;
    tick_d  = 1'b0;
    if (load) begin
      pre_d   = '0;
      div_d   = div;
      count_d = '0;
      sq_d    = 1'b0;
    end else if (en) begin
      if (pre_q == div_q) begin
        pre_d   = '0;
        div_d   = div;
        tick_d  = 1'b1;
        sq_d    = ~sq_q;
        count_d = dir ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end else begin
        pre_d = pre_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      pre_q   <= '0;
      div_q   <= div;
      count_q <= '0;
      sq_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      div_q   <= div_d;
      count_q <= count_d;
      sq_q    <= sq_d;
      tick_q  <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign sq    = sq_q;
  assign count = count_q;
  assign tc    = dir ? (count_q == '1) : (count_q == '0);

endmodule

// File: doc/prog_clkdiv.md
PROG_CLKDIV -- requirements
Module: prog_clkdiv

Interface
REQ-001 The block SHALL have parameter DIV_W, default 26: width of the divisor input and of the prescaler.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the tick counter.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: prescaler and counter advance only while high.
REQ-006 The block SHALL have port div, input, DIV_W bits: divisor; the tick period is div+1 enabled cycles.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous restart of prescaler and counter.
REQ-008 The block SHALL have port dir, input, 1 bit: counter direction, 1 = up, 0 = down.
REQ-009 The block SHALL have port tick, output, 1 bit: registered one-cycle pulse, once per period.
REQ-010 The block SHALL have port sq, output, 1 bit: registered square wave that toggles on every tick.
REQ-011 The block SHALL have port count, output, CNT_W bits: registered tick counter.
REQ-012 The block SHALL have port tc, output, 1 bit: terminal count for the current direction.

Function
REQ-013 The block SHALL hold internal registers pre (DIV_W bits, prescaler) and div_q (DIV_W bits, latched divisor).
REQ-014 Priority on each edge SHALL be: reset_n low, then load high, then en high, then hold.
REQ-015 With en high and pre != div_q, pre SHALL increment by 1, tick SHALL be 0, and count and sq SHALL hold.
REQ-016 With en high and pre == div_q (the wrap edge), the block SHALL set pre to 0, tick to 1, toggle sq, step count by 1 in direction dir, and latch div into div_q.
REQ-017 count SHALL be valid on the same cycle tick is high, i.e. zero added latency between tick and count.
REQ-018 A change on div SHALL take effect only at the next wrap edge or load, never mid-period.
REQ-019 div = 0 SHALL give tick high on every enabled cycle and sq toggling every cycle.
REQ-020 div = all-ones SHALL give a period of 2^DIV_W cycles with no overflow of pre.
REQ-021 Counting up from 2^CNT_W-1 SHALL wrap count to 0; counting down from 0 SHALL wrap count to 2^CNT_W-1.
REQ-022 count arithmetic SHALL be modulo 2^CNT_W, and dir SHALL be sampled on the wrap edge only.
REQ-023 tc SHALL be combinational: (dir AND count == 2^CNT_W-1) OR (NOT dir AND count == 0).
REQ-024 With en low, pre, count, sq and div_q SHALL hold, and tick SHALL be 0 on the next cycle.
REQ-025 Toggling en SHALL NOT restart the period; pre resumes from its held value.
REQ-026 With load high, the block SHALL set pre to 0, count to 0, sq to 0, tick to 0 and div_q to div, regardless of en.
REQ-027 After load, the first tick SHALL occur div+1 enabled cycles later.
REQ-028 tick SHALL never be high on two consecutive cycles unless div_q == 0.

Reset
REQ-029 A reset_n low edge SHALL set pre = 0, count = 0, sq = 0, tick = 0 and div_q = div.
REQ-030 Reset SHALL override load and en, and SHALL abort any period in progress.
REQ-031 After reset_n rises, the first tick SHALL occur on the (div+1)th enabled edge.
REQ-032 No output SHALL change asynchronously to CLOCK_50 except tc, which follows count and dir combinationally.

Verification
REQ-033 Period test: reset, div=3, en=1, dir=1 -> tick on cycles 4, 8, 12, 16, ...; count = 1, 2, 3, 4 on those cycles; sq = 1, 0, 1, 0.
REQ-034 Fast and slow divisor test: div=0 -> tick high every cycle, count increments every cycle; then div=0 with CNT_W=4 run for 16 ticks -> count returns to 0.
REQ-035 Wrap and terminal-count test: dir=1 -> count 14, 15 (tc=1), then 0 (tc=0); switch dir=0 at count 0 -> tc=1, next tick count = 15.
REQ-036 Enable-hold test: div=9, drop en for 5 cycles when pre = 6 -> tick delayed exactly 5 cycles; count and sq unchanged while en is low.
REQ-037 Load and divisor-change test: change div from 9 to 2 mid-period -> current period stays 10 cycles, later periods are 3 cycles; load at count = 7 -> count = 0, sq = 0, next tick 3 cycles later.
REQ-038 Reset-priority test: reset_n low together with load=1 and en=1 mid-period -> all outputs 0 next cycle, and the first tick occurs div+1 cycles after release.
